stream_rr_arbiter: RTL

- Packet-level round-robin arbiter. Shares one valid/ready stream sink between NUM_IN requesters. The sink is typically a ShortFifo input or a shared AXI-Stream datapath.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted.
- Drives a registered output stage tagged with the source index, so downstream logic can route or account per requester.

---
 rtl/stream_rr_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-level round-robin arbiter sharing one valid/ready
// sink between NUM_IN requesters. A grant is held from the first beat to the
// last beat of a packet. Every output beat is registered and tagged with the
// index of the requester that produced it.
module stream_rr_arbiter #(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 16,
   localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN-1:0]        inValid,
   input  logic [NUM_IN-1:0]        inLast,
   input  logic [NUM_IN*DATA_W-1:0] dIn,
   output logic [NUM_IN-1:0]        inReady,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [DATA_W-1:0]        dOut,
   output logic                     outLast,
   output logic [SRC_W-1:0]         outSrc,
   output logic                     busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SRC_W-1:0]    r_grant;
   logic [SRC_W-1:0]    w_grant_nxt;
   logic [SRC_W-1:0]    r_rr_ptr;
   logic [SRC_W-1:0]    w_rr_ptr_nxt;
   logic                r_out_valid;
   logic                w_out_valid_nxt;
   logic [DATA_W-1:0]   r_out_data;
   logic [DATA_W-1:0]   w_out_data_nxt;
   logic                r_out_last;
   logic                w_out_last_nxt;
   logic [SRC_W-1:0]    r_out_src;
   logic [SRC_W-1:0]    w_out_src_nxt;

   logic                w_sel_valid;
   logic                w_sel_last;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_req_any;
   logic [SRC_W-1:0]    w_req_pick;
   logic                w_out_room;
   logic                w_out_fire;
   logic                w_in_fire;

   // Select valid/last/data of the currently granted requester.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_IN; i++) begin
         w_sel_valid = (r_grant == SRC_W'(i)) ? inValid[i] : w_sel_valid;
         w_sel_last  = (r_grant == SRC_W'(i)) ? inLast[i]  : w_sel_last;
         w_sel_data  = (r_grant == SRC_W'(i)) ? dIn[i*DATA_W +: DATA_W] : w_sel_data;
      end
   end

   // Round-robin search: first requesting index at or after the pointer, wrapping.
   always_comb begin
      int               v_idx;
      logic [SRC_W-1:0] v_sel;
      w_req_any  = 1'b0;
      w_req_pick = {SRC_W{1'b0}};
      v_idx      = 0;
      v_sel      = {SRC_W{1'b0}};
      for (int k = 0; k < NUM_IN; k++) begin
         v_idx      = int'(r_rr_ptr) + k;
         v_idx      = (v_idx >= NUM_IN) ? (v_idx - NUM_IN) : v_idx;
         v_sel      = SRC_W'(v_idx);
         w_req_pick = (inValid[v_sel] && !w_req_any) ? v_sel : w_req_pick;
         w_req_any  = w_req_any | inValid[v_sel];
      end
   end

   // Handshake qualifiers; ready only goes to the granted lane and is forced low in reset.
   always_comb begin
      w_out_room = !r_out_valid || outReady;
      w_out_fire = r_out_valid && outReady;
      w_in_fire  = (r_state == ST_GRANT) && w_sel_valid && w_out_room;
      inReady    = {NUM_IN{1'b0}};
      for (int i = 0; i < NUM_IN; i++) begin
         inReady[i] = (r_state == ST_GRANT) && !rst && (r_grant == SRC_W'(i)) && w_out_room;
      end
   end

   // Next-state logic for the arbitration FSM and the output register.
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_out_last_nxt  = r_out_last;
      w_out_src_nxt   = r_out_src;

      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_GRANT;
               w_grant_nxt = w_req_pick;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (w_in_fire && w_sel_last) begin
               // Just-served requester becomes lowest priority.
               w_state_nxt  = ST_IDLE;
               w_rr_ptr_nxt = (r_grant == SRC_W'(NUM_IN - 1)) ? {SRC_W{1'b0}}
                                                              : (r_grant + SRC_W'(1));
            end else begin
               w_state_nxt = ST_GRANT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_in_fire) begin
         // Reload covers the simultaneous accept case, keeping full throughput.
         w_out_valid_nxt = 1'b1;
         w_out_data_nxt  = w_sel_data;
         w_out_last_nxt  = w_sel_last;
         w_out_src_nxt   = r_grant;
      end else if (w_out_fire) begin
         w_out_valid_nxt = 1'b0;
      end else begin
         w_out_valid_nxt = r_out_valid;
      end
   end

   // State and output registers with synchronous reset; reset drops any beat in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= {SRC_W{1'b0}};
         r_rr_ptr    <= {SRC_W{1'b0}};
         r_out_valid <= 1'b0;
         r_out_data  <= {DATA_W{1'b0}};
         r_out_last  <= 1'b0;
         r_out_src   <= {SRC_W{1'b0}};
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_src   <= w_out_src_nxt;
      end
   end

   assign outValid = r_out_valid;
   assign dOut     = r_out_data;
   assign outLast  = r_out_last;
   assign outSrc   = r_out_src;
   assign busy     = (r_state == ST_GRANT);

endmodule
